// File: rtl/viterbi_step_ctrl.sv
// rtl/viterbi_step_ctrl.sv - source/destination sweep sequencer for the Viterbi previous-probability bank
module viterbi_step_ctrl #(
  parameter int word_num     = 16,
  parameter int word_num_bit = 4,
  parameter int p_size       = 32,
  parameter int POS_num      = 11,
  parameter int POS_num_bit  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [word_num_bit:0]   num_words,
  input  logic [p_size-1:0]       P_out,
  input  logic [p_size-1:0]       trans_score,
  input  logic [p_size-1:0]       emit_score,
  output logic [POS_num_bit-1:0]  chose_index,
  output logic [POS_num_bit-1:0]  dst_index,
  output logic [word_num_bit-1:0] word_index,
  output logic                    best_valid,
  output logic [p_size-1:0]       best_score,
  output logic [POS_num_bit-1:0]  best_ptr,
  output logic                    RW_Pre_Posibility,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, SWEEP, EMIT, COMMIT, DONE} state_t;

  localparam logic [POS_num_bit-1:0] POS_LAST  = POS_num_bit'(POS_num - 1);
  localparam logic [word_num_bit:0]  WORDS_MAX = (word_num_bit + 1)'(word_num);

  state_t                   state, state_nxt;
  logic [word_num_bit:0]    num_words_q;
  logic [p_size-1:0]        acc;
  logic [POS_num_bit-1:0]   acc_ptr;
  logic [p_size-1:0]        best_score_q;
  logic [POS_num_bit-1:0]   best_ptr_q;
  logic [p_size-1:0]        cand;
  logic [p_size-1:0]        emit_sum;
  logic [p_size-1:0]        live_score;
  logic [POS_num_bit-1:0]   live_ptr;
  logic                     last_word;

  function automatic logic [p_size-1:0] sat_add(input logic [p_size-1:0] a,
                                                input logic [p_size-1:0] b);
    logic [p_size:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[p_size] ? {p_size{1'b1}} : s[p_size-1:0];
  endfunction

  assign cand      = sat_add(P_out, trans_score);
  assign emit_sum  = sat_add(acc, emit_score);
  assign last_word = ({1'b0, word_index} == num_words_q - (word_num_bit + 1)'(1));

  // Word 0 is the initial column: emission only, no predecessor.
  always_comb begin
    live_score = emit_sum;
    live_ptr   = acc_ptr;
    if (word_index == '0) begin
      live_score = emit_score;
      live_ptr   = '0;
    end
  end

  // The survivor is live during the EMIT cycle and held afterwards.
  assign best_score = best_valid ? live_score : best_score_q;
  assign best_ptr   = best_valid ? live_ptr   : best_ptr_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_words == '0) ? DONE : EMIT;
      SWEEP:   if (chose_index == POS_LAST) state_nxt = EMIT;
      EMIT: begin
        if (dst_index == POS_LAST)   state_nxt = COMMIT;
        else if (word_index == '0)   state_nxt = EMIT;
        else                         state_nxt = SWEEP;
      end
      COMMIT:  state_nxt = last_word ? DONE : SWEEP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      num_words_q       <= '0;
      word_index        <= '0;
      dst_index         <= '0;
      chose_index       <= '0;
      acc               <= '0;
      acc_ptr           <= '0;
      best_score_q      <= '0;
      best_ptr_q        <= '0;
      best_valid        <= 1'b0;
      RW_Pre_Posibility <= 1'b0;
      done              <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_nxt;
      best_valid        <= (state_nxt == EMIT);
      RW_Pre_Posibility <= (state_nxt == COMMIT);
      done              <= (state_nxt == DONE);
      busy              <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            num_words_q <= (num_words > WORDS_MAX) ? WORDS_MAX : num_words;
            word_index  <= '0;
            dst_index   <= '0;
            chose_index <= '0;
          end
        end
        SWEEP: begin
          if (chose_index == '0 || cand > acc) begin
            acc     <= cand;
            acc_ptr <= chose_index;
          end
          chose_index <= (chose_index == POS_LAST) ? '0 : chose_index + POS_num_bit'(1);
        end
        EMIT: begin
          best_score_q <= live_score;
          best_ptr_q   <= live_ptr;
          if (dst_index != POS_LAST) dst_index <= dst_index + POS_num_bit'(1);
        end
        COMMIT: begin
          dst_index <= '0;
          if (!last_word) word_index <= word_index + word_num_bit'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_step_ctrl.sv
// tb/tb_viterbi_step_ctrl.sv - scoreboard bench for viterbi_step_ctrl
module tb_viterbi_step_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  num_words;
  logic [31:0] P_out, trans_score, emit_score;
  logic [3:0]  chose_index, dst_index, best_ptr;
  logic [3:0]  word_index;
  logic        best_valid, RW_Pre_Posibility, busy, done;
  logic [31:0] best_score;

  viterbi_step_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .P_out(P_out), .trans_score(trans_score), .emit_score(emit_score),
    .chose_index(chose_index), .dst_index(dst_index), .word_index(word_index),
    .best_valid(best_valid), .best_score(best_score), .best_ptr(best_ptr),
    .RW_Pre_Posibility(RW_Pre_Posibility), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] score;
    logic [3:0]  ptr;
    logic [3:0]  dst;
    logic [3:0]  word;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mode = 0;
  int   rel, rw_cnt, rw_bad, busy_bad, done_rel;

  function automatic logic [31:0] f_p(input int m, input int s, input int w);
    case (m)
      1: return 32'(s * 5);
      2: return 32'd7;
      3: return 32'hFFFF_FFF0;
      4: return 32'(((s * 3 + w) % 4) * 1000);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_t(input int m, input int s, input int d);
    case (m)
      3: return 32'h20;
      4: return 32'(((s * 7 + d * 3) % 5) * 1000);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_e(input int m, input int w, input int d);
    case (m)
      0: return 32'(d * 10);
      1: return 32'd1;
      2: return 32'(d);
      3: return 32'd5;
      default: return 32'(d * 3 + w);
    endcase
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Bank and score tables respond combinationally to the indices the DUT drives.
  always_comb begin
    P_out       = f_p(mode, int'(chose_index), int'(word_index));
    trans_score = f_t(mode, int'(chose_index), int'(dst_index));
    emit_score  = f_e(mode, int'(word_index), int'(dst_index));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sentence(input int nw, input int m);
    exp_t e;
    logic [31:0] best, c;
    int bp;
    for (int w = 0; w < nw; w++) begin
      for (int d = 0; d < 11; d++) begin
        if (w == 0) begin
          e.score = f_e(m, w, d);
          e.ptr   = 4'd0;
        end else begin
          best = 32'd0;
          bp   = 0;
          for (int s = 0; s < 11; s++) begin
            c = sat(f_p(m, s, w), f_t(m, s, d));
            if (s == 0 || c > best) begin
              best = c;
              bp   = s;
            end
          end
          e.score = sat(best, f_e(m, w, d));
          e.ptr   = 4'(bp);
        end
        e.dst  = 4'(d);
        e.word = 4'(w);
        q.push_back(e);
      end
    end
  endtask

  task automatic observe();
    exp_t e;
    if (best_valid) begin
      n_cmp++;
      assert (q.size() != 0)
      else begin
        n_err++;
        $error("FAIL bv_extra: observed best_valid at rel %0d expected none", rel);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("best_score", best_score, e.score);
        chk("best_ptr", best_ptr, e.ptr);
        chk("bv_dst", dst_index, e.dst);
        chk("bv_word", word_index, e.word);
      end
    end
    if (RW_Pre_Posibility) begin
      if (rel != 12 + 133 * rw_cnt) rw_bad++;
      rw_cnt++;
    end
    if (!busy) busy_bad++;
    if (done && done_rel < 0) done_rel = rel;
  endtask

  task automatic begin_sentence(input int nw, input int m);
    mode = m;
    push_sentence(nw, m);
    rw_cnt = 0; rw_bad = 0; busy_bad = 0; done_rel = -1;
    num_words = 5'(nw);
    start = 1'b1;
    step();
    start = 1'b0;
    rel = 1;
  endtask

  task automatic run_sentence(input int nw, input int m, input int busy_start_rel);
    int exp_done;
    begin_sentence(nw, m);
    exp_done = (nw == 0) ? 1 : 12 + 133 * (nw - 1) + 1;
    while (rel <= 2200) begin
      observe();
      if (done) break;
      if (rel == busy_start_rel) begin
        start = 1'b1;
        num_words = 5'd0;
      end
      step();
      start = 1'b0;
      num_words = 5'(nw);
      rel++;
    end
    chk("done_rel", done_rel, exp_done);
    chk("rw_count", rw_cnt, nw);
    chk("rw_timing", rw_bad, 0);
    chk("busy_gap", busy_bad, 0);
    chk("sb_left", q.size(), 0);
    step();
    chk("busy_after_done", busy, 1'b0);
    chk("done_width", done, 1'b0);
  endtask

  task automatic abort_test();
    int hit, stray;
    hit = 0;
    stray = 0;
    begin_sentence(3, 4);
    while (rel <= 400) begin
      observe();
      if (word_index == 4'd1 && dst_index == 4'd4 && chose_index == 4'd6) begin
        hit = 1;
        break;
      end
      step();
      rel++;
    end
    chk("abort_point", hit, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    q.delete();
    chk("rst_chose", chose_index, 4'd0);
    chk("rst_dst", dst_index, 4'd0);
    chk("rst_word", word_index, 4'd0);
    chk("rst_bv", best_valid, 1'b0);
    chk("rst_score", best_score, 32'd0);
    chk("rst_ptr", best_ptr, 4'd0);
    chk("rst_rw", RW_Pre_Posibility, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (RW_Pre_Posibility || busy || best_valid || done) stray++;
    end
    chk("post_reset_quiet", stray, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_words = 5'd0;
    repeat (3) step();
    chk("init_chose", chose_index, 4'd0);
    chk("init_dst", dst_index, 4'd0);
    chk("init_word", word_index, 4'd0);
    chk("init_bv", best_valid, 1'b0);
    chk("init_score", best_score, 32'd0);
    chk("init_ptr", best_ptr, 4'd0);
    chk("init_rw", RW_Pre_Posibility, 1'b0);
    chk("init_busy", busy, 1'b0);
    chk("init_done", done, 1'b0);
    reset = 1'b0;
    step();

    run_sentence(0, 0, 0);
    run_sentence(1, 0, 0);
    run_sentence(2, 1, 0);
    run_sentence(2, 2, 0);
    run_sentence(2, 3, 0);
    run_sentence(3, 4, 40);
    abort_test();
    run_sentence(16, 4, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
